// File: rtl/pe_2d_flex_if.sv
// Bundle of control, operand and partial-sum signals around one pe_2d_flex.
// Valid semantics: each *_vld/*_load qualifies its data in the same cycle; there is no backpressure.
interface pe_2d_flex_if #(
    parameter int DATA_W = 8,
    parameter int PSUM_W = 20
) ();
    logic                     start;
    logic                     mode;
    logic                     stop;
    logic                     drain;
    logic signed [DATA_W-1:0] w_in;
    logic                     w_load;
    logic                     w_commit;
    logic signed [DATA_W-1:0] fm_in;
    logic                     fm_vld_in;
    logic signed [PSUM_W-1:0] psum_in;
    logic                     psum_vld_in;
    logic signed [DATA_W-1:0] w_out;
    logic                     w_vld_out;
    logic signed [DATA_W-1:0] fm_out;
    logic                     fm_vld_out;
    logic signed [PSUM_W-1:0] psum_out;
    logic                     psum_vld_out;
    logic                     busy;
    logic                     ovf;
    logic [1:0]               dbg_state;

    modport master (
        output start, mode, stop, drain, w_in, w_load, w_commit,
               fm_in, fm_vld_in, psum_in, psum_vld_in,
        input  w_out, w_vld_out, fm_out, fm_vld_out, psum_out, psum_vld_out,
               busy, ovf, dbg_state
    );

    modport slave (
        input  start, mode, stop, drain, w_in, w_load, w_commit,
               fm_in, fm_vld_in, psum_in, psum_vld_in,
        output w_out, w_vld_out, fm_out, fm_vld_out, psum_out, psum_vld_out,
               busy, ovf, dbg_state
    );
endinterface

// File: rtl/pe_2d_flex.sv
// Systolic PE switchable between weight-stationary and output-stationary dataflow.
// Define PE_2D_FLEX_SAT_EN to clamp overflowing sums instead of wrapping.
module pe_2d_flex #(
    parameter int DATA_W = 8,
    parameter int PSUM_W = 20
) (
    input logic         clk,
    input logic         rst_n,
    pe_2d_flex_if.slave bus
);
    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = PSUM_W + 1;
    localparam logic signed [PSUM_W-1:0] PSUM_MAX = {1'b0, {(PSUM_W-1){1'b1}}};
    localparam logic signed [PSUM_W-1:0] PSUM_MIN = {1'b1, {(PSUM_W-1){1'b0}}};

    if (PSUM_W < 2 * DATA_W) begin : g_psum_w_check
        $error("pe_2d_flex: PSUM_W must be at least 2*DATA_W");
    end

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WS_RUN   = 2'd1,
        OS_ACC   = 2'd2,
        OS_DRAIN = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic                     start_ok;
    logic                     pair_vld;
    logic signed [DATA_W-1:0] w_shift_q, w_stat_q, fm_q;
    logic                     w_vld_q, fm_vld_q;
    logic signed [PSUM_W-1:0] psum_q, acc_q;
    logic                     psum_vld_q, ovf_q;

    logic signed [PROD_W-1:0] ws_prod, os_prod;
    logic signed [PSUM_W-1:0] ws_addend, ws_sum, acc_sum;
    logic                     ws_ovf, acc_ovf;

    // Returns {overflow, result}; overflow is flagged identically whether or not the result clamps.
    function automatic logic [PSUM_W:0] add_chk(input logic signed [PSUM_W-1:0] a,
                                                 input logic signed [PSUM_W-1:0] b);
        logic signed [SUM_W-1:0]  s;
        logic                     o;
        logic signed [PSUM_W-1:0] r;
        s = SUM_W'(a) + SUM_W'(b);
        o = s[PSUM_W] ^ s[PSUM_W-1];
        r = s[PSUM_W-1:0];
`ifdef PE_2D_FLEX_SAT_EN
        if (o) r = s[PSUM_W] ? PSUM_MIN : PSUM_MAX;
`else
        r = s[PSUM_W-1:0];
`endif
        return {o, r};
    endfunction

    assign ws_prod   = PROD_W'(w_stat_q) * PROD_W'(bus.fm_in);
    assign os_prod   = PROD_W'(bus.w_in) * PROD_W'(bus.fm_in);
    assign ws_addend = bus.psum_vld_in ? bus.psum_in : '0;
    assign {ws_ovf, ws_sum}   = add_chk(ws_addend, PSUM_W'(ws_prod));
    assign {acc_ovf, acc_sum} = add_chk(acc_q, PSUM_W'(os_prod));

    always_comb begin
        state_d  = state_q;
        start_ok = 1'b0;
        pair_vld = bus.w_load & bus.fm_vld_in;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    start_ok = 1'b1;
                    state_d  = bus.mode ? OS_ACC : WS_RUN;
                end
            end
            WS_RUN:   if (bus.stop)  state_d = IDLE;
            OS_ACC:   if (bus.drain) state_d = OS_DRAIN;
            OS_DRAIN: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_shift_q  <= '0;
            w_stat_q   <= '0;
            w_vld_q    <= 1'b0;
            fm_q       <= '0;
            fm_vld_q   <= 1'b0;
            psum_q     <= '0;
            psum_vld_q <= 1'b0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            if (bus.w_load) w_shift_q <= bus.w_in;
            w_vld_q <= bus.w_load;
            // Commit sees the pre-edge shift stage, so a coincident load lands one commit later.
            if (bus.w_commit) w_stat_q <= w_shift_q;
            if (bus.fm_vld_in) fm_q <= bus.fm_in;
            fm_vld_q <= bus.fm_vld_in;

            case (state_q)
                WS_RUN: begin
                    psum_vld_q <= bus.fm_vld_in;
                    if (bus.fm_vld_in) begin
                        psum_q <= ws_sum;
                        if (ws_ovf) ovf_q <= 1'b1;
                    end
                end
                OS_ACC: begin
                    psum_q     <= bus.psum_in;
                    psum_vld_q <= bus.psum_vld_in;
                    if (pair_vld) begin
                        acc_q <= acc_sum;
                        if (acc_ovf) ovf_q <= 1'b1;
                    end
                end
                OS_DRAIN: begin
                    psum_q     <= acc_q;
                    psum_vld_q <= 1'b1;
                    acc_q      <= '0;
                end
                default: begin
                    psum_q     <= bus.psum_in;
                    psum_vld_q <= bus.psum_vld_in;
                    if (start_ok) begin
                        ovf_q <= 1'b0;
                        acc_q <= '0;
                    end
                end
            endcase
        end
    end

    assign bus.w_out        = w_shift_q;
    assign bus.w_vld_out    = w_vld_q;
    assign bus.fm_out       = fm_q;
    assign bus.fm_vld_out   = fm_vld_q;
    assign bus.psum_out     = psum_q;
    assign bus.psum_vld_out = psum_vld_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.ovf          = ovf_q;
    assign bus.dbg_state    = state_q;
endmodule
